// File: rtl/core_clk_rst_ctrl.sv
// Clock/reset controller for the RV32I core: synchronised, stretched core reset,
// a registered core clock-enable with run/halt/single-step control, and an enabled-cycle counter.
module core_clk_rst_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Step_mode,
  input  logic             Halt_req,
  input  logic             Step_req,
  output logic             Core_rst_n,
  output logic             Core_en,
  output logic             Halted,
  output logic [CNT_W-1:0] Cycle_cnt
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RUN,
    ST_HALT,
    ST_STEP
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [HOLD_W-1:0]      hold_cnt;
  logic                   step_q;
  logic                   rst_sync;
  logic                   release_edge;
  logic                   step_edge;

  assign rst_sync     = sync_q[SYNC_STAGES-1];
  assign release_edge = rst_sync && !Core_rst_n && (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
  assign step_edge    = Step_req && !step_q;

  // NOTE: reset asserts asynchronously but the chain only shifts a 1 in on clock
  // edges, so the core sees a glitch-free synchronous deassertion.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Stretch: count HOLD_CYCLES edges once the synchronised reset has released.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hold_cnt   <= '0;
      Core_rst_n <= 1'b0;
    end else if (release_edge) begin
      Core_rst_n <= 1'b1;
    end else if (rst_sync && !Core_rst_n) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  // NOTE: all state here is sequential, so every assignment is non-blocking; the
  // outputs are registered alongside the state so they never glitch.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= ST_HOLD;
      Core_en <= 1'b0;
      Halted  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      step_q <= Step_req;
      case (state)
        ST_HOLD: begin
          if (release_edge) begin
            if (Step_mode || Halt_req) begin
              state  <= ST_HALT;
              Halted <= 1'b1;
            end else begin
              state   <= ST_RUN;
              Core_en <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (Halt_req || Step_mode) begin
            state   <= ST_HALT;
            Core_en <= 1'b0;
            Halted  <= 1'b1;
          end
        end
        ST_HALT: begin
          // A step request wins over resuming on the same edge.
          if (step_edge) begin
            state   <= ST_STEP;
            Core_en <= 1'b1;
            Halted  <= 1'b0;
          end else if (!Halt_req && !Step_mode) begin
            state   <= ST_RUN;
            Core_en <= 1'b1;
            Halted  <= 1'b0;
          end
        end
        ST_STEP: begin
          state   <= ST_HALT;
          Core_en <= 1'b0;
          Halted  <= 1'b1;
        end
        default: begin
          state   <= ST_HOLD;
          Core_en <= 1'b0;
          Halted  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Cycle_cnt <= '0;
    end else if (Core_en) begin
      Cycle_cnt <= Cycle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_core_clk_rst_ctrl.sv
// Self-checking bench for core_clk_rst_ctrl: directed scenarios plus randomized
// mode/step traffic compared every cycle against a behavioural model.
module tb_core_clk_rst_ctrl;

  localparam int SYNC_STAGES = 2;
  localparam int HOLD_CYCLES = 16;
  localparam int REL_EDGE    = SYNC_STAGES + HOLD_CYCLES;

  logic        Clk       = 1'b0;
  logic        Reset_n   = 1'b1;
  logic        Step_mode = 1'b0;
  logic        Halt_req  = 1'b0;
  logic        Step_req  = 1'b0;
  logic        Core_rst_n, Core_en, Halted;
  logic [31:0] Cycle_cnt;
  logic        Core_rst_n4, Core_en4, Halted4;
  logic [3:0]  Cycle_cnt4;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses;

  core_clk_rst_ctrl #(.SYNC_STAGES(SYNC_STAGES), .HOLD_CYCLES(HOLD_CYCLES), .CNT_W(32)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Step_mode(Step_mode), .Halt_req(Halt_req),
    .Step_req(Step_req), .Core_rst_n(Core_rst_n), .Core_en(Core_en),
    .Halted(Halted), .Cycle_cnt(Cycle_cnt)
  );

  core_clk_rst_ctrl #(.SYNC_STAGES(SYNC_STAGES), .HOLD_CYCLES(HOLD_CYCLES), .CNT_W(4)) dut4 (
    .Clk(Clk), .Reset_n(Reset_n), .Step_mode(Step_mode), .Halt_req(Halt_req),
    .Step_req(Step_req), .Core_rst_n(Core_rst_n4), .Core_en(Core_en4),
    .Halted(Halted4), .Cycle_cnt(Cycle_cnt4)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: edges since release, whether the core is out of reset,
  // whether it is executing and whether the current enabled cycle is a single step.
  int     m_edges    = 0;
  bit     m_out      = 0;
  bit     m_en       = 0;
  bit     m_stepping = 0;
  bit     m_prev_sr  = 0;
  longint m_cnt      = 0;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_edges = 0; m_out = 0; m_en = 0; m_stepping = 0; m_prev_sr = 0; m_cnt = 0;
    end else begin
      bit stop_req;
      stop_req = Halt_req || Step_mode;
      if (m_en) m_cnt++;
      if (m_edges < 1000) m_edges++;
      if (!m_out) begin
        if (m_edges == REL_EDGE) begin
          m_out = 1;
          m_en  = !stop_req;
        end
      end else if (m_stepping) begin
        m_stepping = 0;
        m_en       = 0;
      end else if (m_en) begin
        if (stop_req) m_en = 0;
      end else if (Step_req && !m_prev_sr) begin
        m_en       = 1;
        m_stepping = 1;
      end else if (!stop_req) begin
        m_en = 1;
      end
      m_prev_sr = Step_req;
    end
  end

  always @(negedge Clk) begin
    check("core_rst_n", Core_rst_n, m_out);
    check("core_en", Core_en, m_en);
    check("halted", Halted, m_out && !m_en);
    check("cycle_cnt", Cycle_cnt, m_cnt % (64'd1 << 32));
    check("cycle_cnt4", Cycle_cnt4, m_cnt % 16);
    check("en_in_reset", Core_en && !Core_rst_n, 0);
  end

  task automatic edge_sample();
    @(posedge Clk);
    #1;
  endtask

  // Pulse Reset_n between edges and check that everything clears without a clock.
  task automatic reset_pulse();
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("async_rst_n", Core_rst_n, 0);
    check("async_en", Core_en, 0);
    check("async_cnt", Cycle_cnt, 0);
    check("async_halted", Halted, 0);
    #1 Reset_n = 1'b1;
  endtask

  task automatic release_seq(input bit expect_run);
    for (int k = 1; k <= REL_EDGE; k++) begin
      edge_sample();
      if (k == REL_EDGE - 1) check("rst_before_rel", Core_rst_n, 0);
    end
    check("rst_at_rel", Core_rst_n, 1);
    check("en_at_rel", Core_en, expect_run);
    check("halted_at_rel", Halted, !expect_run);
  endtask

  task automatic drive_step(input bit sr);
    @(negedge Clk);
    Step_req = sr;
    edge_sample();
    if (Core_en) pulses++;
  endtask

  initial begin
    #1 Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_rst_n", Core_rst_n, 0);
    check("reset_en", Core_en, 0);
    check("reset_cnt", Cycle_cnt, 0);
    #2 Reset_n = 1'b1;

    // Free run after release, then five counted cycles.
    release_seq(1'b1);
    repeat (5) edge_sample();
    check("cnt_after_5", Cycle_cnt, 5);

    // Halt for ten cycles: the halting edge still counts, then the counter freezes.
    @(negedge Clk);
    Halt_req = 1'b1;
    edge_sample();
    check("halt_en", Core_en, 0);
    check("halt_flag", Halted, 1);
    check("halt_cnt", Cycle_cnt, 6);
    repeat (9) edge_sample();
    check("halt_frozen", Cycle_cnt, 6);
    @(negedge Clk);
    Halt_req = 1'b0;
    edge_sample();
    check("resume_en", Core_en, 1);
    check("resume_halted", Halted, 0);

    // Asynchronous reset while running, full release repeats.
    reset_pulse();
    release_seq(1'b1);

    // Single-step mode from release: three one-cycle Step_req pulses.
    Step_mode = 1'b1;
    reset_pulse();
    release_seq(1'b0);
    repeat (2) edge_sample();
    pulses = 0;
    for (int p = 0; p < 3; p++) begin
      drive_step(1'b1);
      drive_step(1'b0);
      drive_step(1'b0);
    end
    drive_step(1'b0);
    check("step_pulses", pulses, 3);
    check("step_cnt", Cycle_cnt, 3);

    // Step_req held high gives exactly one step.
    pulses = 0;
    for (int c = 0; c < 20; c++) drive_step(1'b1);
    drive_step(1'b0);
    drive_step(1'b0);
    check("held_pulses", pulses, 1);
    check("held_cnt", Cycle_cnt, 4);

    // Step edge together with leaving step mode: STEP, HALT, then RUN.
    @(negedge Clk);
    Step_mode = 1'b0;
    Step_req  = 1'b1;
    edge_sample();
    check("prio_step_en", Core_en, 1);
    check("prio_step_halted", Halted, 0);
    @(negedge Clk);
    Step_req = 1'b0;
    edge_sample();
    check("prio_halt_en", Core_en, 0);
    check("prio_halt_halted", Halted, 1);
    edge_sample();
    check("prio_run_en", Core_en, 1);
    check("prio_run_halted", Halted, 0);

    // Narrow counter wraps 15 -> 0 -> 1.
    reset_pulse();
    release_seq(1'b1);
    repeat (15) edge_sample();
    check("wrap_15", Cycle_cnt4, 15);
    edge_sample();
    check("wrap_0", Cycle_cnt4, 0);
    edge_sample();
    check("wrap_1", Cycle_cnt4, 1);
    check("wide_17", Cycle_cnt, 17);

    // Randomized traffic, checked every cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk);
      if ($urandom_range(0, 7) == 0) Halt_req = ~Halt_req;
      if ($urandom_range(0, 15) == 0) Step_mode = ~Step_mode;
      if ($urandom_range(0, 2) == 0) Step_req = ~Step_req;
      if ($urandom_range(0, 399) == 0) begin
        #2 Reset_n = 1'b0;
        #2 Reset_n = 1'b1;
      end
    end

    repeat (2) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
